// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states and default datapath geometry
// for the serial subtractor.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF   = 16;
   localparam int SLICE_DEF   = 4;
   localparam int NSLICE_DEF  = WIDTH_DEF / SLICE_DEF;
   localparam int SLICE_IDX_W = (NSLICE_DEF > 1) ? $clog2(NSLICE_DEF) : 1;

endpackage

// File: rtl/sub_slice.sv
// One SLICE-bit subtract cell: a + ~b + cin, reused every cycle by the
// serial subtractor.
module sub_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] diff,
   output logic             cout
);

   logic [SLICE:0] sum;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
      diff = sum[SLICE-1:0];
      cout = sum[SLICE];
   end

endmodule

// File: rtl/alu_sub_serial.sv
// Iterative two's-complement subtractor: one SLICE-bit slice per clock,
// LSB first, with zero/sign/borrow/parity/overflow flags on completion.
module alu_sub_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             zero_flag,
   output logic             sign_flag,
   output logic             carry_flag,
   output logic             parity_flag,
   output logic             overflow_flag,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic [SLICE-1:0] a_sl, b_sl, d_sl;
   logic             c_sl;
   logic             last_slice;
   logic             accept;

   function automatic logic parity_even(input logic [WIDTH-1:0] v);
      return ~^v;
   endfunction

   function automatic logic signed_ovf(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic [WIDTH-1:0] r);
      return (x[WIDTH-1] ^ y[WIDTH-1]) & (r[WIDTH-1] ^ x[WIDTH-1]);
   endfunction

   always_comb begin
      a_sl       = a_q[int'(idx_q)*SLICE +: SLICE];
      b_sl       = b_q[int'(idx_q)*SLICE +: SLICE];
      last_slice = (idx_q == IDX_W'(NSLICE - 1));
      accept     = in_valid && (state == IDLE);
   end

   sub_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .diff (d_sl),
      .cout (c_sl)
   );

   // Partial result stays internal; the diff port only changes on the final slice.
   always_comb begin
      acc_nxt = acc_q;
      acc_nxt[int'(idx_q)*SLICE +: SLICE] = d_sl;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CALC;
         CALC:    if (last_slice) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         idx_q         <= '0;
         carry_q       <= 1'b0;
         diff          <= '0;
         zero_flag     <= 1'b0;
         sign_flag     <= 1'b0;
         carry_flag    <= 1'b0;
         parity_flag   <= 1'b0;
         overflow_flag <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         acc_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b1;
      end else if (state == CALC) begin
         acc_q   <= acc_nxt;
         carry_q <= c_sl;
         idx_q   <= idx_q + IDX_W'(1);
         if (last_slice) begin
            diff          <= acc_nxt;
            zero_flag     <= (acc_nxt == '0);
            sign_flag     <= acc_nxt[WIDTH-1];
            carry_flag    <= ~c_sl;
            parity_flag   <= parity_even(acc_nxt);
            overflow_flag <= signed_ovf(a_q, b_q, acc_nxt);
         end
      end
   end

endmodule

// File: tb/tb_alu_sub_serial.sv
// Directed bench for alu_sub_serial with an arithmetic reference model
// compared on every cycle a result is presented.
module tb_alu_sub_serial;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a = '0, b = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] diff;
   logic        zero_flag, sign_flag, carry_flag, parity_flag, overflow_flag;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic        pending = 1'b0;
   logic [20:0] exp_res = '0;
   logic [4:0]  fl;

   always #5 clk = ~clk;

   assign fl = {zero_flag, sign_flag, carry_flag, parity_flag, overflow_flag};

   alu_sub_serial dut (
      .clk           (clk),
      .rst           (rst),
      .a             (a),
      .b             (b),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .diff          (diff),
      .zero_flag     (zero_flag),
      .sign_flag     (sign_flag),
      .carry_flag    (carry_flag),
      .parity_flag   (parity_flag),
      .overflow_flag (overflow_flag),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
   );

   // Result {diff, Z, S, C, P, V} from plain integer arithmetic.
   function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
      int          ux, uy, sx, sy, sd, ones;
      logic [15:0] r;
      logic        z, s, c, p, v;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 32768) ? ux - 65536 : ux;
      sy = (uy >= 32768) ? uy - 65536 : uy;
      r  = 16'((ux - uy + 65536) % 65536);
      ones = 0;
      for (int i = 0; i < 16; i++) ones += int'(r[i]);
      sd = sx - sy;
      z = (r == 16'd0);
      s = (int'(r) >= 32768);
      c = (ux < uy);
      p = ((ones % 2) == 0);
      v = (sd > 32767) || (sd < -32768);
      return {r, z, s, c, p, v};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_before_issue", {31'b0, in_ready}, 32'd1);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      exp_res  = model(av, bv);
      pending  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = 16'hAAAA;
      b        = 16'h5555;
      chk("busy_in_calc", {31'b0, in_ready}, 32'd0);
      lat = 0;
      while (lat < 10) begin
         if (out_valid) break;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      pending   = 1'b0;
      chk("valid_drops", {31'b0, out_valid}, 32'd0);
      chk("ready_back", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic lit(input string name, input logic [15:0] d, input logic [4:0] f);
      chk({name, "_diff"}, {16'b0, diff}, {16'b0, d});
      chk({name, "_flags"}, {27'b0, fl}, {27'b0, f});
   endtask

   initial begin
      int          lat;
      logic [15:0] d0;
      logic [4:0]  f0;
      logic [31:0] vec [6];
      vec = '{32'hFFFF_FFFF, 32'h8000_7FFF, 32'h7FFF_8000, 32'h0001_8000,
              32'hABCD_1234, 32'h0000_0000};
      fork
         forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
               chk("valid_expected", {31'b0, pending}, 32'd1);
               if (pending) begin
                  chk("model_diff", {16'b0, diff}, {16'b0, exp_res[20:5]});
                  chk("model_flags", {27'b0, fl}, {27'b0, exp_res[4:0]});
                  chk("no_ready_in_done", {31'b0, in_ready}, 32'd0);
               end
            end
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            chk("rst_diff", {16'b0, diff}, 32'd0);
            chk("rst_flags", {27'b0, fl}, 32'd0);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
            rst = 1'b0;

            out_ready = 1'b1;
            repeat (2) begin
               @(posedge clk); #1;
               chk("idle_ready_noeffect_ov", {31'b0, out_valid}, 32'd0);
               chk("idle_ready_noeffect_ir", {31'b0, in_ready}, 32'd1);
            end
            out_ready = 1'b0;

            run_op(16'h0005, 16'h0003, lat);
            chk("latency", lat, 32'd4);
            lit("t1", 16'h0002, 5'b00000);
            consume();

            run_op(16'h1234, 16'h1234, lat);
            lit("t2", 16'h0000, 5'b10010);
            consume();

            run_op(16'h0000, 16'h0001, lat);
            lit("t3", 16'hFFFF, 5'b01110);
            consume();

            run_op(16'h7FFF, 16'hFFFF, lat);
            lit("t5", 16'h8000, 5'b01101);
            consume();

            run_op(16'h8000, 16'h0001, lat);
            lit("t4", 16'h7FFF, 5'b00001);
            a        = 16'h00FF;
            b        = 16'h0001;
            in_valid = 1'b1;
            d0 = diff;
            f0 = fl;
            repeat (3) begin
               @(posedge clk); #1;
               chk("bp_diff", {16'b0, diff}, {16'b0, d0});
               chk("bp_flags", {27'b0, fl}, {27'b0, f0});
               chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
               chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            end
            consume();
            run_op(16'h00FF, 16'h0001, lat);
            chk("bp_latency", lat, 32'd4);
            lit("bp", 16'h00FE, 5'b00000);
            consume();

            a        = 16'h0F0F;
            b        = 16'h0101;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            pending = 1'b0;
            rst     = 1'b1;
            #1;
            lit("rst_mid", 16'h0000, 5'b00000);
            chk("rst_mid_ov", {31'b0, out_valid}, 32'd0);
            chk("rst_mid_ir", {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            lit("rst_hold", 16'h0000, 5'b00000);
            rst = 1'b0;
            run_op(16'h0010, 16'h0008, lat);
            chk("post_rst_latency", lat, 32'd4);
            lit("post_rst", 16'h0008, 5'b00000);
            consume();

            foreach (vec[i]) begin
               run_op(vec[i][31:16], vec[i][15:0], lat);
               chk("vec_latency", lat, 32'd4);
               consume();
            end
            repeat (2) @(posedge clk);
         end
      join_any
      disable fork;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
